// File: rtl/pe_mac_array_if.sv
// Bundles the PE array's job-control, input-beat and result-buffer handshakes.
// The producer side (SRAM read path / sequencer) uses master; the array itself uses slave.
interface pe_mac_array_if #(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int MAX_K      = 512,
    parameter int K_WIDTH    = $clog2(MAX_K + 1)
) ();
    logic                             cfg_start;
    logic [K_WIDTH-1:0]               cfg_k_len;
    logic                             in_valid;
    logic                             in_ready;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_w;
    logic [DATA_WIDTH-1:0]            in_v;
    logic                             out_valid;
    logic                             out_ready;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data;
    logic [ARRAY_SIZE-1:0]            out_sat;
    logic                             busy;

    modport master (
        output cfg_start, cfg_k_len, in_valid, in_w, in_v, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  cfg_start, cfg_k_len, in_valid, in_w, in_v, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/pe_mac_array.sv
// Array of ARRAY_SIZE signed MAC lanes: two-stage multiply/accumulate pipeline with
// saturating accumulators, feeding a single-entry result buffer so the next job can overlap.
module pe_mac_array #(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int MAX_K      = 512,
    parameter int K_WIDTH    = $clog2(MAX_K + 1)
) (
    input logic              clk,
    input logic              srst,
    pe_mac_array_if.slave    bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [K_WIDTH-1:0] MAX_K_W = K_WIDTH'(MAX_K);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, WB} state_t;

    state_t                          state_q, state_d;
    logic [K_WIDTH-1:0]              k_len_q, k_len_d;
    logic [K_WIDTH-1:0]              cnt_q, cnt_d;
    logic [PW-1:0]                   prod_q [ARRAY_SIZE];
    logic [PW-1:0]                   prod_d [ARRAY_SIZE];
    logic                            prod_vld_q, prod_vld_d;
    logic [ACC_WIDTH-1:0]            acc_q [ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]            acc_d [ARRAY_SIZE];
    logic [ARRAY_SIZE-1:0]           sat_q, sat_d;
    logic                            out_valid_q, out_valid_d;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [ARRAY_SIZE-1:0]           out_sat_q, out_sat_d;

    logic                            accept;
    logic                            k_ok;
    logic                            wb_load;
    logic [PW-1:0]                   w_ext;
    logic [PW-1:0]                   v_ext;
    logic [ACC_WIDTH:0]              sum;

    assign accept       = bus.in_valid && (state_q == ACCUM);
    assign k_ok         = (bus.cfg_k_len != '0) && (bus.cfg_k_len <= MAX_K_W);
    assign wb_load      = (state_q == WB) && (!out_valid_q || bus.out_ready);

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        prod_vld_d  = accept;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        w_ext       = '0;
        sum         = '0;
        v_ext       = {{DATA_WIDTH{bus.in_v[DATA_WIDTH-1]}}, bus.in_v};

        // Operands are sign-extended to the product width first, so the truncated
        // unsigned product equals the exact signed product.
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_ext = {{DATA_WIDTH{bus.in_w[i*DATA_WIDTH+DATA_WIDTH-1]}},
                     bus.in_w[i*DATA_WIDTH +: DATA_WIDTH]};
            if (accept) begin
                prod_d[i] = w_ext * v_ext;
            end
            if (prod_vld_q) begin
                sum = {acc_q[i][ACC_WIDTH-1], acc_q[i]}
                    + {{(ACC_WIDTH+1-PW){prod_q[i][PW-1]}}, prod_q[i]};
                if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                    acc_d[i] = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                    sat_d[i] = 1'b1;
                end else begin
                    acc_d[i] = sum[ACC_WIDTH-1:0];
                end
            end
        end

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cfg_start && k_ok) begin
                    k_len_d = bus.cfg_k_len;
                    cnt_d   = '0;
                    sat_d   = '0;
                    for (int i = 0; i < ARRAY_SIZE; i++) begin
                        acc_d[i] = '0;
                    end
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + K_WIDTH'(1);
                    if (cnt_q == k_len_q - K_WIDTH'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = WB;
            end
            WB: begin
                // Reloading on the consume edge keeps out_valid high back-to-back.
                if (wb_load) begin
                    for (int i = 0; i < ARRAY_SIZE; i++) begin
                        out_data_d[(ARRAY_SIZE-i)*ACC_WIDTH-1 -: ACC_WIDTH] = acc_q[i];
                    end
                    out_sat_d   = sat_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            cnt_q       <= '0;
            prod_vld_q  <= 1'b0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                prod_q[i] <= '0;
                acc_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            cnt_q       <= cnt_d;
            prod_vld_q  <= prod_vld_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                prod_q[i] <= prod_d[i];
                acc_q[i]  <= acc_d[i];
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_array.sv
// Directed bench for a 4-lane pe_mac_array: table-driven jobs plus hand-written
// back-pressure, saturation, mid-job reset and ignored-start sequences.
module tb_pe_mac_array;
    localparam int AS   = 4;
    localparam int DW   = 16;
    localparam int AW   = 40;
    localparam int MAXK = 512;
    localparam int KW   = 10;

    logic clk = 1'b0;
    logic srst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pe_mac_array_if #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MAXK)) bus ();

    pe_mac_array #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MAXK)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [KW-1:0]          k;
        logic [0:3][DW-1:0]     w;
        logic [0:3][DW-1:0]     v;
        logic [3:0]             gap;
        logic [0:3][AW-1:0]     exp_data;
        logic [3:0]             exp_sat;
    } vec_t;

    vec_t vecs [5];
    vec_t sat_vec;
    vec_t small_vec;
    vec_t post_rst_vec;

    task automatic checkOutput(input string name, input logic [AS*AW-1:0] act,
                               input logic [AS*AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic startJob(input logic [KW-1:0] k);
        bus.cfg_start = 1'b1;
        bus.cfg_k_len = k;
        @(posedge clk);
        #1;
        bus.cfg_start = 1'b0;
    endtask

    task automatic feedBeat(input logic [0:3][DW-1:0] w, input logic [DW-1:0] v);
        int   tries = 0;
        logic rdy;
        for (int i = 0; i < AS; i++) bus.in_w[i*DW +: DW] = w[i];
        bus.in_v     = v;
        bus.in_valid = 1'b1;
        do begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end while (!rdy && tries < 20);
        if (!rdy) checkOutput("beat_accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t t);
        startJob(t.k);
        for (int b = 0; b < int'(t.k); b++) begin
            feedBeat(t.w, t.v[b % 4]);
            if (b != int'(t.k) - 1) begin
                repeat (int'(t.gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runVector(input string name, input vec_t t);
        int lat;
        applyStimulus(t);
        waitValid(lat);
        checkOutput({name, "_latency"}, lat, 2);
        checkOutput({name, "_data"}, bus.out_data, t.exp_data);
        checkOutput({name, "_sat"}, bus.out_sat, t.exp_sat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [0:3][DW-1:0] ones;
        logic [0:3][AW-1:0] exp_a;
        int lat;

        ones = {16'd1, 16'd1, 16'd1, 16'd1};

        vecs[0] = '{k: 10'd4, w: {16'd1, 16'd2, 16'd3, 16'd4}, v: {16'd1, 16'd2, 16'd3, 16'd4},
                    gap: 4'd0, exp_data: {40'd10, 40'd20, 40'd30, 40'd40}, exp_sat: 4'b0000};
        vecs[1] = '{k: 10'd3, w: {16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD},
                    v: {16'd5, 16'hFFF9, 16'd2, 16'd0}, gap: 4'd2,
                    exp_data: {40'd0, 40'd0, 40'd0, 40'd0}, exp_sat: 4'b0000};
        vecs[2] = '{k: 10'd3, w: {16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD},
                    v: {16'd5, 16'd7, 16'd2, 16'd0}, gap: 4'd2,
                    exp_data: {-40'sd42, -40'sd42, -40'sd42, -40'sd42}, exp_sat: 4'b0000};
        vecs[3] = '{k: 10'd2, w: {16'd100, 16'hFF9C, 16'h7FFF, 16'h8000},
                    v: {16'hFFFE, 16'd3, 16'd0, 16'd0}, gap: 4'd1,
                    exp_data: {40'd100, -40'sd100, 40'd32767, -40'sd32768}, exp_sat: 4'b0000};
        vecs[4] = '{k: 10'd1, w: {16'hFFFF, 16'd0, 16'd1, 16'd7},
                    v: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, gap: 4'd0,
                    exp_data: {40'd32768, 40'd0, -40'sd32768, -40'sd229376}, exp_sat: 4'b0000};

        sat_vec = '{k: 10'd512, w: {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF},
                    v: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, gap: 4'd0,
                    exp_data: {40'h7F_FFFF_FFFF, -40'sd549739036672,
                               40'h7F_FFFF_FFFF, -40'sd549739036672},
                    exp_sat: 4'b0101};
        small_vec = '{k: 10'd1, w: {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                      v: {16'd1, 16'd1, 16'd1, 16'd1}, gap: 4'd0,
                      exp_data: {40'd32767, 40'd32767, 40'd32767, 40'd32767}, exp_sat: 4'b0000};
        post_rst_vec = '{k: 10'd1, w: {16'd2, 16'd2, 16'd2, 16'd2},
                         v: {16'd3, 16'd3, 16'd3, 16'd3}, gap: 4'd0,
                         exp_data: {40'd6, 40'd6, 40'd6, 40'd6}, exp_sat: 4'b0000};

        srst          = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_k_len = '0;
        bus.in_valid  = 1'b0;
        bus.in_w      = '0;
        bus.in_v      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_out_sat", bus.out_sat, 0);
        srst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Job A held by back-pressure while job B accumulates and stalls in WB.
        bus.out_ready = 1'b0;
        applyStimulus(vecs[0]);
        waitValid(lat);
        checkOutput("bp_a_latency", lat, 2);
        exp_a = vecs[0].exp_data;
        startJob(10'd2);
        feedBeat(ones, 16'd5);
        feedBeat(ones, 16'd6);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_a_stable%0d", c), bus.out_data, exp_a);
        end
        checkOutput("bp_busy_in_wb", bus.busy, 1);
        checkOutput("bp_in_ready_in_wb", bus.in_ready, 0);
        checkOutput("bp_a_valid_held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_b_valid_stays", bus.out_valid, 1);
        checkOutput("bp_b_data", bus.out_data, {40'd11, 40'd11, 40'd11, 40'd11});
        checkOutput("bp_b_sat", bus.out_sat, 0);
        @(posedge clk);
        #1;
        checkOutput("bp_b_consumed", bus.out_valid, 0);
        checkOutput("bp_idle_after", bus.busy, 0);

        runVector("sat512", sat_vec);
        runVector("after_sat", small_vec);

        // Abort a job halfway; nothing from it may surface later.
        startJob(10'd4);
        feedBeat(ones, 16'd9);
        feedBeat(ones, 16'd9);
        checkOutput("midjob_in_ready", bus.in_ready, 1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        runVector("post_reset", post_rst_vec);

        startJob(10'd0);
        checkOutput("ignore_k0_busy", bus.busy, 0);
        startJob(10'd513);
        checkOutput("ignore_k513_busy", bus.busy, 0);
        startJob(10'd3);
        feedBeat(ones, 16'd1);
        bus.cfg_start = 1'b1;
        bus.cfg_k_len = 10'd1;
        feedBeat(ones, 16'd2);
        bus.cfg_start = 1'b0;
        checkOutput("ignore_accum_still_ready", bus.in_ready, 1);
        feedBeat(ones, 16'd3);
        waitValid(lat);
        checkOutput("ignore_accum_latency", lat, 2);
        checkOutput("ignore_accum_data", bus.out_data, {40'd6, 40'd6, 40'd6, 40'd6});
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_mac_array.md
Name: pe_mac_array

Overview:
- Parametrised successor to the existing PE core.
- Each accepted beat carries one weight column of ARRAY_SIZE lanes and one vector element. Every lane does acc[i] += w[i]*v.
- After a run-time K length, the lane results go to a holding output buffer with valid/ready handshake.
- Signed fixed-point arithmetic with saturating accumulation and per-lane overflow flags. Sits between the SRAM read path and the result write-back.

Parameters:
- ARRAY_SIZE, 32, number of lanes (PEs).
- DATA_WIDTH, 16, signed width of each weight and of the vector element.
- ACC_WIDTH, 40, signed accumulator/output width per lane; must be ≥ 2*DATA_WIDTH.
- MAX_K, 512, maximum accumulation depth.
- K_WIDTH, $clog2(MAX_K+1), width of cfg_k_len.

Ports:
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  synchronous active-high reset.
- cfg_start  in  1  one-cycle job start pulse; honoured only in IDLE.
- cfg_k_len  in  K_WIDTH  beats per job, sampled with cfg_start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  high only in ACCUM.
- in_w  in  ARRAY_SIZE*DATA_WIDTH  weight column; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_v  in  DATA_WIDTH  vector element, shared by all lanes.
- out_valid  out  1  result buffer full.
- out_ready  in  1  consumer accepts result.
- out_data  out  ARRAY_SIZE*ACC_WIDTH  results; lane i at bits [(ARRAY_SIZE-i)*ACC_WIDTH-1 -: ACC_WIDTH], so lane 0 is at the MSB end.
- out_sat  out  ARRAY_SIZE  per-lane saturation flag; bit i = lane i. Valid with out_data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: srst high at an edge drives state=IDLE, beat counter=0, product-valid=0, accumulators=0, sat flags=0, out_valid=0, out_data=0, out_sat=0, in_ready=0, busy=0.
- Reset mid-job aborts the job. The partial result is discarded and never appears on out_data.
- FSM states: IDLE, ACCUM, FLUSH, WB.
- IDLE:
  - cfg_start with cfg_k_len in 1..MAX_K latches k_len, clears beat counter, accumulators and sat flags, then goes to ACCUM.
  - cfg_k_len=0 or >MAX_K: cfg_start is ignored and the block stays IDLE.
  - cfg_start in any other state is ignored.
- ACCUM:
  - A beat is accepted when in_valid && in_ready.
  - Stage 1 registers prod[i] = w[i]*v (full 2*DATA_WIDTH signed) and a product-valid bit.
  - Stage 2 adds a valid product to acc[i] on the next edge. Accumulation is pipelined, so a beat can be accepted every cycle.
  - Accepting beat number k_len (counter == k_len-1) moves the state to FLUSH.
  - Idle cycles (in_valid low) insert bubbles with no effect.
- FLUSH: one cycle; the final product is added to the accumulators. The state then goes to WB.
- WB:
  - If out_valid==0, or out_valid && out_ready this cycle: at the edge, out_data<=acc, out_sat<=sat flags, out_valid<=1, and the state goes to IDLE.
  - Otherwise the block stays in WB, holding acc.
- Latency: out_valid rises 2 edges after the edge that accepted the last beat, provided the buffer is free.
- Output handshake:
  - out_data and out_sat are stable while out_valid && !out_ready.
  - out_valid clears on an edge with out_ready high, unless WB reloads on that same edge; in that case it stays 1 with the new data.
- Double buffering: a new job may start and accumulate while the previous result waits in the output buffer. It stalls only in WB.
- Arithmetic:
  - Sum = acc + sign-extended product, computed at ACC_WIDTH+1 bits.
  - On overflow, saturate to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1) and set the sticky sat flag for that lane for this job.
  - Once saturated, later additions continue from the clamped value.
- in_ready is combinational from state only. It is 0 in IDLE, FLUSH and WB.

Test Plan:
- Basic: ARRAY_SIZE=4, DATA_WIDTH=16, ACC_WIDTH=40, k_len=4, w[i]=i+1 every beat, v=1,2,3,4 back-to-back, out_ready=1 -> out_valid rises exactly 2 cycles after the 4th accept. Lane i = 10*(i+1), so out_data MSB lane=10 and LSB lane=40; out_sat=0.
- Signed/bubbles: k_len=3, w[i]=-3, v=5,-7,2 with in_valid low for 2 cycles between beats -> every lane = 0 (sign-correct sum is -3*0 = 0). Repeat with v=5,7,2 -> every lane = -42; bubbles are ignored.
- Back-pressure: job A result held with out_ready=0 for 10 cycles; job B (k_len=2) started meanwhile -> B waits in WB, busy=1, A's data stable. On out_ready=1, A is consumed and B loads on the same edge with out_valid staying 1.
- Saturation: ACC_WIDTH=32, w=32767 all lanes, v=32767, k_len=3 -> lanes = 32'h7FFFFFFF, out_sat=all ones. Next job k_len=1, v=1 -> lanes=32767, out_sat=0.
- Reset mid-job: srst high after 2 of 4 beats -> next cycle busy=0, in_ready=0, out_valid=0. A fresh k_len=1 job (w=2, v=3) gives 6 per lane with no residue.
- Ignored starts: cfg_start with k_len=0, k_len=MAX_K+1, and during ACCUM -> no state change; beat count and result of the ongoing job are unaffected.
